// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one byte-FIFO write port with glitch-free strobe.
// Optional stall counter output enabled by FIFO_WRITE_ARBITER_STATS_EN.
module fifo_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_request,
  input  logic [N_REQ*8-1:0] i_data,
  output logic [N_REQ-1:0]   o_ack,
  input  logic               i_fifo_full,
  output logic               o_fifo_write,
  output logic [7:0]         o_fifo_wdata,
  output logic               o_busy,
  output logic [ID_W-1:0]    o_grant_id
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  ,
  output logic [31:0]        o_stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    ACK
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [ID_W-1:0]  cand [N_REQ];
  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic [7:0]       pick_data;

  // Candidates in priority order: ptr+1, ptr+2, ... wrapping modulo N_REQ
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cand[i] = ID_W'((int'(ptr_q) + i + 1) % N_REQ);
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && i_request[cand[i]]) begin
        pick_found = 1'b1;
        pick_id    = cand[i];
      end
    end
    pick_data = i_data[{pick_id, 3'b000} +: 8];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found && !i_fifo_full) begin
          gid_d   = pick_id;
          wdata_d = pick_data;
          state_d = SETUP;
        end
      end
      SETUP: begin
        write_d = 1'b1;
        state_d = STROBE;
      end
      STROBE: begin
        ack_d[gid_q] = 1'b1;
        state_d      = ACK;
      end
      ACK: begin
        ptr_d   = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);
      gid_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      ack_q   <= ack_d;
    end
  end

  assign o_fifo_write = write_q;
  assign o_ack        = ack_q;
  assign o_fifo_wdata = wdata_q;
  assign o_grant_id   = gid_q;
  assign o_busy       = (state_q != IDLE);

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && (|i_request) && i_fifo_full
        && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_count = stall_q;
`endif

endmodule
